usb_piso_stream: RTL
====================

Name: usb_piso_stream

Overview:
Parametrised parallel-in/serial-out serialiser for the USB transmit path. It accepts words over a valid/ready handshake into a single-entry holding buffer. Words are shifted out one bit per shift_enable strobe, MSB- or LSB-first. Back-to-back words within a packet stream with no bit gap, and end-of-packet, underrun and abort are all handled explicitly.

Parameters:
DATA_W, 8, word width in bits (≥2)
LSB_FIRST, 1, 1 = bit 0 leaves first (USB order); 0 = MSB first
IDLE_BIT, 1'b1, serial_out value after reset and after abort

Ports:
clk  in  1  system clock
RST  in  1  synchronous, active-high reset
in_valid  in  1  word offered
in_data  in  DATA_W  word to serialise
in_last  in  1  word is final word of packet (qualified by in_valid)
in_ready  out  1  holding buffer empty; registered, no combinational path from inputs
shift_enable  in  1  bit strobe; one bit emitted per strobe while shifting
abort  in  1  synchronous flush of all state
serial_out  out  1  registered serial bit
serial_valid  out  1  1-cycle pulse; serial_out updated this cycle
busy  out  1  state == SHIFT
word_done  out  1  1-cycle pulse after last bit of a word leaves
pkt_done  out  1  1-cycle pulse when the last bit of an in_last word leaves
underrun  out  1  1-cycle pulse when a non-last word finishes with buffer empty

Behaviour:
- Reset (RST=1 at clk edge): state=IDLE, hold_valid=0, bit_cnt=0, serial_out=IDLE_BIT; in_ready=1; all other outputs 0.
- Accept: in_valid && in_ready at edge → hold_data/hold_last captured, hold_valid=1, in_ready=0 next cycle.
- States: IDLE, SHIFT.
- IDLE → SHIFT: at the edge where hold_valid=1, the hold contents move to the shifter, bit_cnt=0 and hold_valid=0. Minimum latency: accept at edge N, SHIFT at N+1, first bit shifted on the first shift_enable edge ≥ N+2.
- shift_enable is ignored in IDLE.
- SHIFT, shift_enable=1:
  - serial_out ← next bit (LSB_FIRST: shifter[0] then shift right; else shifter[DATA_W-1] then shift left); serial_valid=1 next cycle; bit_cnt+1.
  - When bit_cnt == DATA_W-1, same edge: word_done=1 and bit_cnt=0, then:
    - if cur_last: pkt_done=1, go IDLE. A waiting hold word is loaded on the following edge.
    - else if hold_valid: load hold into shifter at the same edge, stay SHIFT (gapless), hold_valid=0.
    - else: underrun=1, go IDLE.
- SHIFT with shift_enable=0: all state holds; serial_out unchanged.
- Simultaneous buffer refill and shifter load cannot occur on one edge, because in_ready derives from registered hold_valid.
- bit_cnt width: $clog2(DATA_W); wrap is explicit at DATA_W-1, never natural overflow.
- serial_out holds its last bit in IDLE after pkt_done or underrun.
- abort (priority over everything except RST): same effect as reset. No done, underrun or word_done pulses are generated; a partial word is discarded.
- RST or abort mid-word: the same discard rules apply.
- busy=1 exactly while state==SHIFT.

Decomposition:
- Package usb_tx_pkg:
  - state enum piso_state_t {IDLE, SHIFT}
  - localparam USB_BYTE_W = 8
- Sub-module usb_tx_hold_buf: single-entry valid/ready buffer carrying {last, data}, with a pop input and abort/RST clearing.
- The shifter, counter and FSM stay in usb_piso_stream.

Test Plan:
- Single word (DATA_W=8, LSB_FIRST=1): accept 0xB4, in_last=1, shift_enable every cycle.
  - Required: serial_out sequence 0,0,1,0,1,1,0,1 with 8 serial_valid pulses.
  - Required: word_done and pkt_done together after bit 8, then busy=0.
- MSB-first (LSB_FIRST=0): accept 0xB4, in_last=1.
  - Required: serial_out sequence 1,0,1,1,0,1,0,0.
- Gapless pair: accept 0x01 (last=0), then 0x80 (last=1) while the first word shifts; shift_enable continuous.
  - Required: 16 consecutive serial_valid pulses with no gap.
  - Required: two word_done pulses, one pkt_done, no underrun.
- Underrun: accept 0xFF (last=0), no further words.
  - Required: after 8 bits, underrun=1 for one cycle, busy=0, pkt_done=0.
- Sparse strobe: shift_enable every 4th cycle on 0x55 (last=1).
  - Required: bits appear only on strobe edges; pkt_done 1 cycle after the 8th strobe.
- Abort mid-word: after 3 bits of 0xB4, assert abort.
  - Required next cycle: busy=0, in_ready=1, serial_out=1, no word_done/pkt_done.
  - Required: the next word 0x0F serialises correctly from bit 0.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_pkg
// Shared types and constants for the USB transmit serialiser slice.
//   piso_state_t : serialiser FSM state (IDLE / SHIFT)
//   USB_BYTE_W   : natural USB word width, used as the default data width
// -----------------------------------------------------------------------------
package usb_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int USB_BYTE_W = 8;

endpackage

// File: rtl/usb_tx_hold_buf.sv
// -----------------------------------------------------------------------------
// usb_tx_hold_buf
// Single-entry valid/ready holding buffer carrying {last, data} between the
// word producer and the serialiser's shift register.
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   abort_i        synchronous flush (same effect as reset)
//   push_valid_i   producer offers a word
//   push_data_i    offered word
//   push_last_i    offered word ends the packet
//   push_ready_o   registered: buffer empty and able to accept
//   pop_i          consumer takes the held word this edge
//   hold_valid_o   buffer holds a word
//   hold_data_o    held word
//   hold_last_o    held word ends the packet
// -----------------------------------------------------------------------------
module usb_tx_hold_buf
  import usb_tx_pkg::*;
#(
  parameter int DATA_W = USB_BYTE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              abort_i,
  input  logic              push_valid_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  output logic              push_ready_o,
  input  logic              pop_i,
  output logic              hold_valid_o,
  output logic [DATA_W-1:0] hold_data_o,
  output logic              hold_last_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              ready_q, ready_d;
  logic              accept_s;

  // Push only when the registered ready says the slot is empty; a push and a
  // pop can therefore never coincide (pop requires the slot to be full).
  assign accept_s = push_valid_i && ready_q;

  // Next-state for the holding slot and its registered ready flag.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (accept_s) begin
      valid_d = 1'b1;
      data_d  = push_data_i;
      last_d  = push_last_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    // ready is computed from the next occupancy so it is a pure register output
    ready_d = ~valid_d;
  end

  // Slot registers with reset/abort flush.
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  assign push_ready_o = ready_q;
  assign hold_valid_o = valid_q;
  assign hold_data_o  = data_q;
  assign hold_last_o  = last_q;

endmodule

// File: rtl/usb_piso_stream.sv
// -----------------------------------------------------------------------------
// usb_piso_stream
// Parallel-in/serial-out serialiser for the USB transmit path. Words arrive
// over valid/ready into a one-entry holding buffer and are shifted out one bit
// per shift_enable strobe. Consecutive words of a packet stream with no bit
// gap; end-of-packet, underrun and abort are signalled/handled explicitly.
// Ports:
//   clk           system clock
//   RST           synchronous active-high reset
//   in_valid      word offered
//   in_data       word to serialise
//   in_last       word is the final word of its packet
//   in_ready      registered: holding buffer empty
//   shift_enable  bit strobe (ignored in IDLE)
//   abort         synchronous flush of all state
//   serial_out    registered serial bit
//   serial_valid  pulse: serial_out updated this cycle
//   busy          FSM is in SHIFT
//   word_done     pulse: last bit of a word has left
//   pkt_done      pulse: last bit of an in_last word has left
//   underrun      pulse: non-last word finished with an empty buffer
// -----------------------------------------------------------------------------
module usb_piso_stream
  import usb_tx_pkg::*;
#(
  parameter int   DATA_W    = USB_BYTE_W,
  parameter bit   LSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              shift_enable,
  input  logic              abort,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              busy,
  output logic              word_done,
  output logic              pkt_done,
  output logic              underrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  piso_state_t       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              cur_last_q, cur_last_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              serial_out_q, serial_out_d;
  logic              serial_valid_q, serial_valid_d;
  logic              word_done_q, word_done_d;
  logic              pkt_done_q, pkt_done_d;
  logic              underrun_q, underrun_d;

  logic              pop_s;
  logic              hold_valid_s;
  logic [DATA_W-1:0] hold_data_s;
  logic              hold_last_s;

  usb_tx_hold_buf #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk_i        (clk),
    .rst_i        (RST),
    .abort_i      (abort),
    .push_valid_i (in_valid),
    .push_data_i  (in_data),
    .push_last_i  (in_last),
    .push_ready_o (in_ready),
    .pop_i        (pop_s),
    .hold_valid_o (hold_valid_s),
    .hold_data_o  (hold_data_s),
    .hold_last_o  (hold_last_s)
  );

  // FSM next-state, shifter, bit counter and registered output pulses.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    cur_last_d     = cur_last_q;
    bit_cnt_d      = bit_cnt_q;
    serial_out_d   = serial_out_q;
    serial_valid_d = 1'b0;
    word_done_d    = 1'b0;
    pkt_done_d     = 1'b0;
    underrun_d     = 1'b0;
    pop_s          = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_valid_s) begin
          shreg_d    = hold_data_s;
          cur_last_d = hold_last_s;
          bit_cnt_d  = '0;
          pop_s      = 1'b1;
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (shift_enable) begin
          serial_valid_d = 1'b1;
          if (LSB_FIRST) begin
            serial_out_d = shreg_q[0];
            shreg_d      = {1'b0, shreg_q[DATA_W-1:1]};
          end else begin
            serial_out_d = shreg_q[DATA_W-1];
            shreg_d      = {shreg_q[DATA_W-2:0], 1'b0};
          end

          if (bit_cnt_q == LAST_CNT) begin
            // Final bit of the word: explicit wrap, then decide what follows.
            word_done_d = 1'b1;
            bit_cnt_d   = '0;
            if (cur_last_q) begin
              // A waiting word is picked up from IDLE on the next edge.
              pkt_done_d = 1'b1;
              state_d    = IDLE;
            end else if (hold_valid_s) begin
              // Gapless: next word enters the shifter on this same edge.
              shreg_d    = hold_data_s;
              cur_last_d = hold_last_s;
              pop_s      = 1'b1;
              state_d    = SHIFT;
            end else begin
              underrun_d = 1'b1;
              state_d    = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = SHIFT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; abort flushes exactly like reset.
  always_ff @(posedge clk) begin
    if (RST || abort) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      cur_last_q     <= 1'b0;
      bit_cnt_q      <= '0;
      serial_out_q   <= IDLE_BIT;
      serial_valid_q <= 1'b0;
      word_done_q    <= 1'b0;
      pkt_done_q     <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      cur_last_q     <= cur_last_d;
      bit_cnt_q      <= bit_cnt_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      word_done_q    <= word_done_d;
      pkt_done_q     <= pkt_done_d;
      underrun_q     <= underrun_d;
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign busy         = (state_q == SHIFT);
  assign word_done    = word_done_q;
  assign pkt_done     = pkt_done_q;
  assign underrun     = underrun_q;

endmodule
